// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered 8N1 UART.
// Register map, status bit positions, FSM encodings and baud helper.
package uart_pkg;

    localparam logic REG_STATUS = 1'b0;
    localparam logic REG_DATA   = 1'b1;

    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_TX_IDLE   = 4;
    localparam int ST_RX_IE     = 5;
    localparam int ST_TX_IE     = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] BIT_END  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);

    typedef struct packed {
        logic rd_status;
        logic rd_data;
        logic wr_ctrl;
        logic wr_data;
    } bus_op_t;

    // Oversample tick period in clocks, rounded, never below 1.
    function automatic int calc_divisor(int clkspeed, int baud);
        int d;
        d = (clkspeed + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_fifo_io_if.sv
// CPU IO bus window for the buffered UART.
// The CPU side is master; the peripheral is slave.
interface uart_fifo_io_if;

    logic        cs_b;
    logic        rnw;
    logic        a0;
    logic [15:0] din;
    logic [15:0] dout;

    modport master (
        output cs_b, rnw, a0, din,
        input  dout
    );

    modport slave (
        input  cs_b, rnw, a0, din,
        output dout
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head output.
// Pointers carry an extra wrap bit so full/empty need no counter.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << LOG2;
    localparam logic [LOG2:0] PTR_ONE = 1;

    logic [LOG2:0]      wp_q, wp_d;
    logic [LOG2:0]      rp_q, rp_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    // Flags and pointer updates; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty   = (wp_q == rp_q);
        full    = (wp_q[LOG2] != rp_q[LOG2]) &&
                  (wp_q[LOG2-1:0] == rp_q[LOG2-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wp_d    = do_push ? wp_q + PTR_ONE : wp_q;
        rp_d    = do_pop ? rp_q + PTR_ONE : rp_q;
        rdata   = mem_q[rp_q[LOG2-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wp_q[LOG2-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_fifo_io.sv
// Buffered 8N1 UART on the CPU IO bus: TX/RX FIFOs,
// 16x oversampled receiver, status register and interrupt request.
module uart_fifo_io
    import uart_pkg::*;
#(
    parameter int CLKSPEED  = 32000000,
    parameter int BAUD      = 115200,
    parameter int FIFO_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset_b,
    uart_fifo_io_if.slave  bus,
    input  logic           rxd,
    output logic           txd,
    output logic           irq_b
);

    localparam int DIVISOR = calc_divisor(CLKSPEED, BAUD);
    localparam int TCW     = $clog2(DIVISOR + 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(DIVISOR - 1);
    localparam logic [TCW-1:0] TICK_ONE  = 1;

    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic           tick;

    bus_op_t        op;
    logic           unused_din;

    logic           tx_pop, tx_full, tx_empty;
    logic [7:0]     tx_rdata;
    logic [1:0]     tx_state_q, tx_state_d;
    logic [3:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]     tx_bit_q, tx_bit_d;
    logic [7:0]     tx_shift_q, tx_shift_d;
    logic           tx_idle;

    logic [1:0]     rx_sync_q, rx_sync_d;
    logic           rx_s;
    logic           rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]     rx_rdata;
    logic [1:0]     rx_state_q, rx_state_d;
    logic [3:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic           rx_armed_q, rx_armed_d;

    logic           overrun_q, overrun_d, overrun_set;
    logic           frame_err_q, frame_err_d, frame_set;
    logic           rx_ie_q, rx_ie_d;
    logic           tx_ie_q, tx_ie_d;
    logic [15:0]    status;

    assign unused_din = ^bus.din[15:8];

    // Free-running oversample tick, one clk wide at counter wrap.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
    end

    // Decode one bus access per selected cycle.
    always_comb begin
        op.rd_status = ~bus.cs_b & bus.rnw & (bus.a0 == REG_STATUS);
        op.rd_data   = ~bus.cs_b & bus.rnw & (bus.a0 == REG_DATA);
        op.wr_ctrl   = ~bus.cs_b & ~bus.rnw & (bus.a0 == REG_STATUS);
        op.wr_data   = ~bus.cs_b & ~bus.rnw & (bus.a0 == REG_DATA);
    end

    uart_sync_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_tx_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (op.wr_data),
        .pop     (tx_pop),
        .wdata   (bus.din[7:0]),
        .rdata   (tx_rdata),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_rx_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (rx_push),
        .pop     (rx_pop),
        .wdata   (rx_shift_q),
        .rdata   (rx_rdata),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // Transmit shifter: start, 8 data bits LSB first, stop; 16 ticks each.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tick) begin
            unique case (tx_state_q)
                S_IDLE: begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_cnt_d   = '0;
                        tx_state_d = S_START;
                    end
                end
                S_START: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == BIT_END) begin
                        tx_bit_d   = '0;
                        tx_state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == BIT_END) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == BIT_END) begin
                        tx_state_d = S_IDLE;
                    end
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
    end

    // Line level follows the shifter state so reset idles it at once.
    always_comb begin
        unique case (tx_state_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    // Receive deserialiser with start-bit glitch rejection.
    always_comb begin
        rx_sync_d   = {rx_sync_q[0], rxd};
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_armed_d  = rx_armed_q | rx_s;
        rx_push     = 1'b0;
        overrun_set = 1'b0;
        frame_set   = 1'b0;
        if (tick) begin
            unique case (rx_state_q)
                S_IDLE: begin
                    if (rx_armed_q && !rx_s) begin
                        rx_cnt_d   = '0;
                        rx_state_d = S_START;
                    end
                end
                S_START: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_d == MID_TICK) begin
                        if (!rx_s) begin
                            rx_cnt_d   = '0;
                            rx_bit_d   = '0;
                            rx_state_d = S_DATA;
                        end else begin
                            rx_state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == BIT_END) begin
                        rx_shift_d = {rx_s, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == BIT_END) begin
                        rx_state_d = S_IDLE;
                        if (rx_s) begin
                            if (!rx_full || rx_pop) begin
                                rx_push = 1'b1;
                            end else begin
                                overrun_set = 1'b1;
                            end
                        end else begin
                            frame_set  = 1'b1;
                            rx_armed_d = 1'b0;
                        end
                    end
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    // Sticky flags clear on status read unless set again this cycle.
    always_comb begin
        rx_pop      = op.rd_data & ~rx_empty;
        overrun_d   = overrun_set | (overrun_q & ~op.rd_status);
        frame_err_d = frame_set | (frame_err_q & ~op.rd_status);
        rx_ie_d     = op.wr_ctrl ? bus.din[0] : rx_ie_q;
        tx_ie_d     = op.wr_ctrl ? bus.din[1] : tx_ie_q;
        tx_idle     = tx_empty & (tx_state_q == S_IDLE);
    end

    // Read mux; unselected or write cycles return zero.
    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = ~rx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_OVERRUN]   = overrun_q;
        status[ST_FRAME_ERR] = frame_err_q;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_RX_IE]     = rx_ie_q;
        status[ST_TX_IE]     = tx_ie_q;
        unique case (1'b1)
            op.rd_status: bus.dout = status;
            op.rd_data:   bus.dout = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
            default:      bus.dout = 16'h0000;
        endcase
        irq_b = ~((rx_ie_q & ~rx_empty) | (tx_ie_q & ~tx_full));
    end

    // All control state, asynchronously reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tick_cnt_q  <= '0;
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            rx_sync_q   <= 2'b11;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_armed_q  <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            rx_sync_q   <= rx_sync_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_armed_q  <= rx_armed_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
        end
    end

    assign rx_s = rx_sync_q[1];

endmodule
